// File: rtl/flappy_scroll_ctrl.sv
// Flappy Bird scroll sequencer: IDLE/PLAY/OVER control, scroll-tick divider, pipe shift and score.
// Optional FLAPPY_SPEEDUP_EN shortens the tick period every 8 pipes passed.
module flappy_scroll_ctrl #(
  parameter int unsigned TICK_DIV  = 200,
  parameter int unsigned SHIFT_MAX = 16,
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned HOLDOFF   = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         collision_i,
  input  logic                         pause_i,
  output logic [1:0]                   state_o,
  output logic                         scroll_tick_o,
  output logic [$clog2(SHIFT_MAX)-1:0] shift_o,
  output logic [SCORE_W-1:0]           pipe_cnt_o,
  output logic                         gameover_o,
  output logic                         clear_field_o
);

  localparam int unsigned DivW   = $clog2(TICK_DIV + 1);
  localparam int unsigned ShiftW = $clog2(SHIFT_MAX);
  localparam int unsigned HoldW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [DivW-1:0]    TickDiv   = DivW'(TICK_DIV);
  localparam logic [ShiftW-1:0]  ShiftLast = ShiftW'(SHIFT_MAX - 1);
  localparam logic [HoldW-1:0]   HoldInit  = HoldW'(HOLDOFF - 1);
  localparam logic [SCORE_W-1:0] PipeMax   = '1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPlay = 2'd1;
  localparam logic [1:0] StOver = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [ShiftW-1:0]  shift_q, shift_d;
  logic [SCORE_W-1:0] pipe_cnt_q, pipe_cnt_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               tick_q, tick_d;
  logic               clear_q, clear_d;
  logic               gameover_q, gameover_d;
  logic [DivW-1:0]    cur_div;
  logic [DivW-1:0]    div_last;

  assign div_last = cur_div - DivW'(1);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    shift_d    = shift_q;
    pipe_cnt_d = pipe_cnt_q;
    hold_d     = hold_q;
    tick_d     = 1'b0;
    clear_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StPlay;
          shift_d    = '0;
          pipe_cnt_d = '0;
          div_d      = '0;
          clear_d    = 1'b1;
        end
      end
      StPlay: begin
        // Collision wins over pause and over a same-cycle terminal count.
        if (collision_i) begin
          state_d = StOver;
          hold_d  = HoldInit;
        end else if (!pause_i) begin
          if (div_q == div_last) begin
            div_d  = '0;
            tick_d = 1'b1;
            if (shift_q == ShiftLast) begin
              shift_d = '0;
              if (pipe_cnt_q != PipeMax) begin
                pipe_cnt_d = pipe_cnt_q + SCORE_W'(1);
              end
            end else begin
              shift_d = shift_q + ShiftW'(1);
            end
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
      end
      StOver: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HoldW'(1);
        end else if (start_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    gameover_d = (state_d == StOver);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      div_q      <= '0;
      shift_q    <= '0;
      pipe_cnt_q <= '0;
      hold_q     <= '0;
      tick_q     <= 1'b0;
      clear_q    <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      pipe_cnt_q <= pipe_cnt_d;
      hold_q     <= hold_d;
      tick_q     <= tick_d;
      clear_q    <= clear_d;
      gameover_q <= gameover_d;
    end
  end

`ifdef FLAPPY_SPEEDUP_EN
  localparam logic [DivW-1:0] DivStep = DivW'(TICK_DIV / 4);

  logic [DivW-1:0]    cur_div_q, cur_div_d;
  logic [SCORE_W-1:0] pipe_inc;
  logic               speed_step;

  always_comb begin
    pipe_inc   = pipe_cnt_q + SCORE_W'(1);
    // Step on the tick that moves the score onto a nonzero multiple of 8.
    speed_step = tick_d && (shift_q == ShiftLast) && (pipe_cnt_q != PipeMax) &&
                 (pipe_inc[2:0] == 3'd0);
    cur_div_d  = cur_div_q;
    if ((state_q == StIdle) && start_i) begin
      cur_div_d = TickDiv;
    end else if (speed_step) begin
      cur_div_d = (cur_div_q >= (DivStep << 1)) ? (cur_div_q - DivStep) : DivStep;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_div_q <= TickDiv;
    end else begin
      cur_div_q <= cur_div_d;
    end
  end

  assign cur_div = cur_div_q;
`else
  assign cur_div = TickDiv;
`endif

  assign state_o       = state_q;
  assign scroll_tick_o = tick_q;
  assign shift_o       = shift_q;
  assign pipe_cnt_o    = pipe_cnt_q;
  assign gameover_o    = gameover_q;
  assign clear_field_o = clear_q;

endmodule

// File: tb/tb_flappy_scroll_ctrl.sv
// Self-checking bench for flappy_scroll_ctrl; expected scroll ticks are queued when a game
// starts and matched by a negedge monitor. Build with FLAPPY_SPEEDUP_EN to cover speedup.
module tb_flappy_scroll_ctrl;

`ifdef FLAPPY_SPEEDUP_EN
  localparam int TD = 8;
`else
  localparam int TD = 4;
`endif
  localparam int SM = 16;
  localparam int HO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] state;
  logic       scroll_tick;
  logic [3:0] shift;
  logic [7:0] pipe_cnt;
  logic       gameover;
  logic       clear_field;

  flappy_scroll_ctrl #(
    .TICK_DIV  (TD),
    .SHIFT_MAX (SM),
    .SCORE_W   (8),
    .HOLDOFF   (HO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .collision_i   (collision),
    .pause_i       (pause),
    .state_o       (state),
    .scroll_tick_o (scroll_tick),
    .shift_o       (shift),
    .pipe_cnt_o    (pipe_cnt),
    .gameover_o    (gameover),
    .clear_field_o (clear_field)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int shift;
    int pipe;
  } tick_t;

  tick_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ticks_seen = 0;
  bit    mon_en = 1'b1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every observed tick must match the next queued expectation in time, shift and score.
  always @(negedge clk) begin
    if (!rst && scroll_tick) begin
      ticks_seen++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_tick", cyc, -1);
        end else begin
          tick_t e;
          e = exp_q.pop_front();
          check_eq("tick_cycle", cyc, e.cyc);
          check_eq("tick_shift", shift, e.shift);
          check_eq("tick_pipe", pipe_cnt, e.pipe);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic push_tick(input int c, input int s, input int p);
    tick_t e;
    e.cyc = c;
    e.shift = s;
    e.pipe = p;
    exp_q.push_back(e);
  endtask

  task automatic start_game(output int c);
    start = 1'b1;
    step(1);
    start = 1'b0;
    c = cyc;
  endtask

  task automatic wait_pipe(input int target, input int limit, output bit ok);
    int n;
    n = 0;
    while (pipe_cnt != 8'(target) && n < limit) begin
      step(1);
      n++;
    end
    ok = (pipe_cnt == 8'(target));
  endtask

  task automatic measure_interval(output int iv);
    int t0;
    int n;
    t0 = cyc;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!scroll_tick && n < 100);
    iv = scroll_tick ? (cyc - t0) : -1;
  endtask

  initial begin
    int cn, ce, cm, cp, iv;
    bit ok;

    #2 rst = 1'b1;
    #2;
    check_eq("rst_state", state, 0);
    check_eq("rst_shift", shift, 0);
    check_eq("rst_pipe", pipe_cnt, 0);
    check_eq("rst_tick", scroll_tick, 0);
    check_eq("rst_gameover", gameover, 0);
    check_eq("rst_clear", clear_field, 0);
    step(2);
    @(negedge clk) rst = 1'b0;
    step(2);
    check_eq("idle_hold", state, 0);

    // Game 1: 16 ticks over one full wrap.
    ticks_seen = 0;
    start_game(cn);
    check_eq("play_state", state, 1);
    check_eq("clear_pulse", clear_field, 1);
    for (int k = 1; k <= 16; k++) push_tick(cn + TD * k, k % SM, k / SM);
    step(1);
    check_eq("clear_drop", clear_field, 0);
    go_to(cn + 16 * TD + 1);
    check_eq("wrap_ticks", ticks_seen, 16);
    check_eq("wrap_shift", shift, 0);
    check_eq("wrap_pipe", pipe_cnt, 1);

    // Three paused cycles stretch the next interval by three.
    push_tick(cn + 17 * TD + 3, 1, 1);
    push_tick(cn + 18 * TD + 3, 2, 1);
    pause = 1'b1;
    step(3);
    check_eq("pause_shift", shift, 0);
    pause = 1'b0;

    // Collision on the terminal-count edge suppresses the tick.
    go_to(cn + 19 * TD + 2);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    ce = cyc;
    check_eq("over_state", state, 2);
    check_eq("over_gameover", gameover, 1);
    check_eq("over_no_tick", scroll_tick, 0);
    check_eq("over_shift", shift, 2);
    check_eq("over_pipe", pipe_cnt, 1);
    check_eq("queue_drained", exp_q.size(), 0);

    go_to(ce + 2);
    start_game(cm);
    check_eq("holdoff_drop", state, 2);
    go_to(ce + HO - 1);
    start_game(cm);
    check_eq("holdoff_accept", state, 0);
    check_eq("idle_gameover", gameover, 0);
    check_eq("idle_keep_shift", shift, 2);
    check_eq("idle_keep_pipe", pipe_cnt, 1);

    // Game 2: asynchronous reset mid-play at shift 9.
    step(1);
    start_game(cm);
    for (int k = 1; k <= 9; k++) push_tick(cm + TD * k, k, 0);
    go_to(cm + 9 * TD + 1);
    check_eq("pre_rst_shift", shift, 9);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_state", state, 0);
    check_eq("arst_shift", shift, 0);
    check_eq("arst_pipe", pipe_cnt, 0);
    check_eq("arst_tick", scroll_tick, 0);
    check_eq("arst_clear", clear_field, 0);
    check_eq("arst_queue", exp_q.size(), 0);
    @(negedge clk) rst = 1'b0;
    step(2);
    check_eq("post_rst_idle", state, 0);
    start_game(cp);
    push_tick(cp + TD, 1, 0);
    go_to(cp + TD + 1);
    check_eq("restart_shift", shift, 1);
    check_eq("restart_pipe", pipe_cnt, 0);
    check_eq("restart_queue", exp_q.size(), 0);

    mon_en = 1'b0;
`ifdef FLAPPY_SPEEDUP_EN
    wait_pipe(8, 20000, ok);
    check_eq("reach_pipe8", ok, 1);
    measure_interval(iv);
    check_eq("interval_pipe8", iv, TD - TD / 4);
    wait_pipe(24, 20000, ok);
    check_eq("reach_pipe24", ok, 1);
    measure_interval(iv);
    check_eq("interval_pipe24", iv, TD / 4);
    wait_pipe(32, 20000, ok);
    check_eq("reach_pipe32", ok, 1);
    measure_interval(iv);
    check_eq("interval_pipe32", iv, TD / 4);
`endif

    // Score saturates at 255 and stays there through a further wrap.
    wait_pipe(255, 256 * SM * TD + 100, ok);
    check_eq("reach_pipe255", ok, 1);
    step(SM * TD + 2 * TD);
    check_eq("pipe_saturate", pipe_cnt, 255);
    check_eq("sat_still_play", state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flappy_scroll_ctrl.md
# flappy_scroll_ctrl

Game-level sequencer for the Flappy Bird pipe-scrolling datapath. Owns the IDLE/PLAY/OVER state machine, divides the system clock into scroll ticks, and advances the pipe column shift (0..SHIFT_MAX-1). Counts pipes passed and freezes the field on collision. Sits between the input conditioning (start button, collision detector) and the pipe renderer / score display.

## Interface
- TICK_DIV, 200: clock cycles per scroll step in PLAY; legal range 4..65535.
- SHIFT_MAX, 16: shift positions per pipe column; shift wraps SHIFT_MAX-1 -> 0.
- SCORE_W, 8: width of pipe_cnt.
- HOLDOFF, 64: cycles in OVER during which start is ignored; legal range ≥1.
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  synchronous single-cycle pulse from the debounced flap/start button.
- collision  in  1  synchronous level from the collision detector; sampled in PLAY only.
- pause  in  1  synchronous level; freezes scrolling in PLAY.
- state  out  2  0=IDLE, 1=PLAY, 2=OVER; encoding 3 never driven.
- scroll_tick  out  1  one-cycle pulse per shift step.
- shift  out  $clog2(SHIFT_MAX)  current column offset.
- pipe_cnt  out  SCORE_W  pipes passed this game, saturating.
- gameover  out  1  high exactly while state==OVER.
- clear_field  out  1  one-cycle pulse on entry to PLAY; the renderer reloads pipe heights.

## Operation
- Reset (async assert, any time): state=IDLE, shift=0, pipe_cnt=0, scroll_tick=0, gameover=0, clear_field=0, divider=0, holdoff counter=0, cur_div=TICK_DIV.
- IDLE: all outputs static. start -> PLAY; on that edge shift=0, pipe_cnt=0, divider=0, cur_div=TICK_DIV, clear_field=1 for the next cycle.
- PLAY: divider counts 0..cur_div-1 while pause=0; holds value while pause=1. When divider==cur_div-1 and pause=0: divider->0, scroll_tick=1 next cycle, shift increments. If shift==SHIFT_MAX-1, shift->0 and pipe_cnt increments; pipe_cnt saturates at 2^SCORE_W-1.
- PLAY: collision=1 -> OVER on the next edge. Collision has priority over a same-cycle terminal count: no tick, no shift/pipe_cnt change. Collision overrides pause. start is ignored in PLAY.
- OVER: gameover=1; shift and pipe_cnt hold final values. The holdoff counter loads HOLDOFF-1 on entry and decrements to 0. start while the counter is nonzero is dropped. start with the counter at 0 -> IDLE; shift and pipe_cnt keep their values until the next IDLE->PLAY.
- collision and pause are don't-care outside PLAY.

## Timing
- All outputs registered; no combinational input->output paths.
- start in IDLE at edge N: state=PLAY and clear_field=1 after edge N; clear_field=0 after edge N+1.
- First scroll_tick occurs cur_div cycles after entering PLAY. Ticks are exactly cur_div cycles apart with pause=0. Each paused cycle extends the interval by one.
- shift and pipe_cnt update on the same edge that raises scroll_tick.
- collision sampled at edge N: state=OVER and gameover=1 after edge N.
- First accepted start in OVER is HOLDOFF cycles after entry.
- Reset deassertion mid-game always restarts in IDLE.

## Configuration
- FLAPPY_SPEEDUP_EN defined: every time pipe_cnt increments to a nonzero multiple of 8, cur_div decreases by TICK_DIV/4 (integer), floored at TICK_DIV/4. The new value applies from the next divider period. cur_div resets to TICK_DIV on IDLE->PLAY.
- FLAPPY_SPEEDUP_EN undefined: cur_div is constant TICK_DIV. No speedup logic is synthesised.

## Test plan
Bench overrides: TICK_DIV=4, SHIFT_MAX=16, HOLDOFF=8.
- Reset then start -> clear_field single pulse; first scroll_tick 4 cycles after entering PLAY; shift=1, pipe_cnt=0.
- Run 64 cycles in PLAY -> 16 ticks; shift wraps 15->0 exactly once; pipe_cnt=1.
- pause high for 3 cycles mid-period -> that tick interval = 7 cycles; shift sequence unchanged.
- collision on the terminal-count cycle -> state=2, gameover=1, no tick, shift and pipe_cnt unchanged. start 3 cycles after entering OVER is ignored. start 8 cycles after entering OVER -> state=0.
- Assert rst asynchronously mid-PLAY with shift=9 -> all outputs zero immediately, state=0; the next start restarts from shift=0.
- With FLAPPY_SPEEDUP_EN and TICK_DIV=8: after pipe_cnt reaches 8, the tick interval is 6 cycles. After pipe_cnt reaches 24, the interval floors at 2 cycles and stays there at 32.
